// File: rtl/adding_machine_reader.sv
// rtl/adding_machine_reader.sv - word-memory reader that sums a zero-terminated word list
// Optional build macro: AM_READER_SIGNED_OVF_EN (overflow flags signed two's-complement overflow
// instead of unsigned carry-out).

module adding_machine_reader #(
  parameter logic [29:0] BASE_ADDR = 30'd0,
  parameter int          MAX_WORDS = 256,
  parameter int          COUNT_W   = 9
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  output logic [29:0]        addr,
  input  logic [31:0]        data,
  output logic [31:0]        sum,
  output logic [COUNT_W-1:0] count,
  output logic               overflow,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [29:0]        addr_q, addr_d;
  logic [31:0]        sum_q, sum_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [32:0]        add_full;
  logic [COUNT_W-1:0] count_inc;
  logic               add_ovf;

  // Adder shared by the RUN state; the overflow flavour is chosen at build time.
  always_comb begin
    add_full  = {1'b0, sum_q} + {1'b0, data};
    count_inc = count_q + COUNT_W'(1);
`ifdef AM_READER_SIGNED_OVF_EN
    add_ovf   = (sum_q[31] == data[31]) && (add_full[31] != sum_q[31]);
`else
    add_ovf   = add_full[32];
`endif
  end

  // Next-state and datapath update; busy/done are derived from the next state so they
  // come out of flops alongside the state itself.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = BASE_ADDR;
          sum_d   = 32'd0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (data == 32'd0) begin
          // Terminator: not counted, pointer stays on it.
          state_d = S_DONE;
        end else begin
          sum_d   = add_full[31:0];
          ovf_d   = ovf_q | add_ovf;
          count_d = count_inc;
          addr_d  = addr_q + 30'd1;
          if (count_inc == COUNT_W'(MAX_WORDS)) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      sum_q   <= 32'd0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign addr     = addr_q;
  assign sum      = sum_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_adding_machine_reader.sv
// tb/tb_adding_machine_reader.sv - directed self-checking bench for adding_machine_reader

module tb_adding_machine_reader;

  localparam int COUNT_W = 9;

  logic               clock;
  logic               reset_n;
  logic               start;
  logic [29:0]        addr;
  logic [31:0]        data;
  logic [31:0]        sum;
  logic [COUNT_W-1:0] count;
  logic               overflow;
  logic               busy;
  logic               done;

  logic [31:0] mem [0:15];

  int tests_run = 0;
  int tests_failed = 0;

  adding_machine_reader #(
    .BASE_ADDR(30'd0),
    .MAX_WORDS(4),
    .COUNT_W  (COUNT_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .addr    (addr),
    .data    (data),
    .sum     (sum),
    .count   (count),
    .overflow(overflow),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational memory model.
  always_comb data = mem[addr[3:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load_mem(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [31:0] w3, input logic [31:0] fill);
    for (int i = 0; i < 16; i++) mem[i] = fill;
    mem[0] = w0;
    mem[1] = w1;
    mem[2] = w2;
    mem[3] = w3;
  endtask

  // Leaves the caller 1ns after the start edge.
  task automatic pulse_start();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen, bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input int cyc, input int exp_cyc,
                              input logic [31:0] exp_sum, input int exp_cnt, input logic exp_ovf);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_latency"}, cyc, exp_cyc);
    check_eq({tag, "_sum"}, sum, exp_sum);
    check_eq({tag, "_count"}, {23'd0, count}, exp_cnt);
    check_eq({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  initial begin
    int cyc;
    logic exp_ovf_a;
    logic exp_ovf_b;

    reset_n = 1'b0;
    start   = 1'b0;
    load_mem(32'd1, 32'd2, 32'd3, 32'd0, 32'd0);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_sum", sum, 32'd0);
    check_eq("rst_addr", {2'd0, addr}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Idle with no start for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check_eq("idle_hold", {30'd0, busy, done}, 32'd0);
    end

    // Basic sum with address stepping.
    pulse_start();
    check_eq("basic_busy0", {31'd0, busy}, 32'd1);
    check_eq("basic_addr0", {2'd0, addr}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clock); #1;
      check_eq("basic_addr_step", {2'd0, addr}, i);
    end
    cyc = 3;
    wait_done(cyc);
    cyc = cyc + 3;
    check_result("basic", cyc, 4, 32'd6, 3, 1'b0);
    check_eq("basic_addr_end", {2'd0, addr}, 32'd3);

`ifdef AM_READER_SIGNED_OVF_EN
    exp_ovf_a = 1'b0;
    exp_ovf_b = 1'b1;
`else
    exp_ovf_a = 1'b1;
    exp_ovf_b = 1'b0;
`endif

    // 0xFFFFFFFF + 2: carry out, but no signed overflow.
    load_mem(32'hFFFF_FFFF, 32'h0000_0002, 32'd0, 32'd0, 32'd0);
    pulse_start();
    wait_done(cyc);
    check_result("ovf_a", cyc, 3, 32'h0000_0001, 2, exp_ovf_a);

    // 0x7FFFFFFF + 1: signed overflow, no carry out.
    load_mem(32'h7FFF_FFFF, 32'h0000_0001, 32'd0, 32'd0, 32'd0);
    pulse_start();
    wait_done(cyc);
    check_result("ovf_b", cyc, 3, 32'h8000_0000, 2, exp_ovf_b);

    // Clean rerun clears the sticky flag.
    load_mem(32'd1, 32'd2, 32'd3, 32'd0, 32'd0);
    pulse_start();
    wait_done(cyc);
    check_result("clean", cyc, 4, 32'd6, 3, 1'b0);

    // Count limit: word at address 4 must not be read.
    load_mem(32'h10, 32'h10, 32'h10, 32'h10, 32'h10);
    pulse_start();
    wait_done(cyc);
    check_result("limit", cyc, 4, 32'h40, 4, 1'b0);
    check_eq("limit_addr", {2'd0, addr}, 32'd4);
    repeat (3) @(posedge clock);
    #1;
    check_eq("limit_hold_sum", sum, 32'h40);
    check_eq("limit_hold_addr", {2'd0, addr}, 32'd4);
    check_eq("limit_hold_done", {31'd0, done}, 32'd1);

    // Start pulse during RUN is ignored.
    load_mem(32'd5, 32'd6, 32'd7, 32'd0, 32'd0);
    pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(cyc);
    cyc = cyc + 1;
    check_result("start_in_run", cyc, 4, 32'd18, 3, 1'b0);

    // Asynchronous reset mid-run, mid-cycle.
    load_mem(32'h10, 32'h10, 32'h10, 32'd0, 32'd0);
    pulse_start();
    @(posedge clock); #1;
    @(posedge clock); #3;
    check_eq("pre_rst_sum", sum, 32'h20);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_sum", sum, 32'd0);
    check_eq("midrst_count", {23'd0, count}, 32'd0);
    check_eq("midrst_addr", {2'd0, addr}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_eq("postrst_idle", {30'd0, busy, done}, 32'd0);
    load_mem(32'd1, 32'd2, 32'd3, 32'd0, 32'd0);
    pulse_start();
    wait_done(cyc);
    check_result("fresh", cyc, 4, 32'd6, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/adding_machine_reader.md
Name: adding_machine_reader

Overview:
- Initiator side of the adding machine word-memory interface.
- After `start`, walks word addresses from a base address and reads one 32-bit word per clock from the memory's combinational data port.
- Accumulates a running 32-bit sum until it reads a zero terminator word or hits a word-count limit.
- Sits between the control/test harness and the adding machine memory; presents the result on `sum` with a `done` level.

Parameters:
- BASE_ADDR, 0, first word address driven on addr after start (30-bit value).
- MAX_WORDS, 256, maximum number of non-zero words accumulated per run; range 1..511.
- COUNT_W, 9, width of count output; must hold MAX_WORDS.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a run when not busy
- addr  output  30  word address to memory; equals internal pointer register
- data  input  32  memory read data; valid within the same cycle addr is stable (memory is combinational, delay < clock period)
- sum  output  32  accumulated sum, modulo 2^32
- count  output  COUNT_W  number of words added in the current/last run
- overflow  output  1  sticky; set if any addition produced carry-out of bit 31
- busy  output  1  high in RUN
- done  output  1  high in DONE (level, not pulse)

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (reset_n low, asynchronous):
  - state=IDLE, addr=BASE_ADDR, sum=0, count=0, overflow=0, busy=0, done=0.
  - Reset mid-run abandons the run immediately; no partial result is retained.
- IDLE/DONE + start=1 at clock edge:
  - sum=0, count=0, overflow=0, addr=BASE_ADDR, state=RUN.
- DONE without start: holds sum, count, overflow and addr indefinitely.
- RUN:
  - addr is held for the whole cycle; data is sampled at the next rising edge. Throughput is one word per cycle.
  - If data==0: state=DONE; sum, count and addr unchanged. The terminator is not counted.
  - Else:
    - sum=sum+data (33-bit add; bit 32 ORs into overflow).
    - count=count+1; addr=addr+1 (30-bit wrap, 0x3FFFFFFF -> 0).
    - If the incremented count==MAX_WORDS, state=DONE in the same edge.
- start while in RUN is ignored; the run continues unaffected.
- Latency: a list of N non-zero words followed by a zero gives done high N+1 cycles after the start edge. A list reaching MAX_WORDS gives done high MAX_WORDS cycles after the start edge.
- busy and done are registered, mutually exclusive, and never both high.
- All outputs are registered; no combinational path from data to any output.

Optional Feature:
- Macro: AM_READER_SIGNED_OVF_EN.
- Defined:
  - overflow is signed two's-complement overflow: operands have the same sign and the result sign differs. Still sticky.
  - Unsigned carry is ignored.
- Undefined: overflow is unsigned carry-out of bit 31, as above.
- Port list is identical in both builds.

Test Plan:
- Reset/idle: assert reset_n=0 mid-cycle -> all outputs at reset values immediately, addr=BASE_ADDR; release with no start -> state stays IDLE for 10 cycles.
- Basic sum: memory words 1,2,3,0 at BASE_ADDR=0; pulse start -> addr steps 0,1,2,3; done high 4 cycles after start; sum=6, count=3, overflow=0.
- Unsigned overflow (macro undefined): words 0xFFFFFFFF, 0x00000002, 0 -> sum=0x00000001, count=2, overflow=1. Rerun on a clean list -> overflow cleared to 0.
- Count limit: MAX_WORDS=4, eight consecutive words of 0x10 -> done after 4 cycles; sum=0x40, count=4, addr=BASE_ADDR+4; memory at addr 4 is not read.
- Start during RUN and reset mid-run: start pulse on cycle 2 of a 5-word run -> result identical to an undisturbed run. reset_n low on cycle 3 -> IDLE, sum=0; a fresh start completes correctly.
- Signed overflow (AM_READER_SIGNED_OVF_EN defined): words 0x7FFFFFFF, 0x00000001, 0 -> sum=0x80000000, overflow=1. Words 0xFFFFFFFF, 0x00000001, 0 -> sum=0, overflow=0.
